// File: rtl/pkt_rr_arb2_pkg.sv
// Shared definitions for the two-source round-robin packet arbiter:
// FSM state encodings, grant source codes and the default payload width.
package pkt_rr_arb2_pkg;

    localparam int DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GNT_A = 3'd1,
        ST_GNT_B = 3'd2,
        ST_DRP_A = 3'd3,
        ST_DRP_B = 3'd4
    } state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // True while source A holds the grant, either forwarding or dropping.
    function automatic logic owned_by_a(input state_t st);
        return (st == ST_GNT_A) || (st == ST_DRP_A);
    endfunction

endpackage

// File: rtl/pkt_rr_arb2_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the source that did not
// win last time is chosen, otherwise the single requester wins.
module pkt_rr_arb2_rr_pick2
    import pkt_rr_arb2_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_sel
);

    // Tie-break against the previous winner; req[0] is source A, req[1] is source B.
    always_comb begin
        gnt_valid = |req;
        if (req == 2'b11) begin
            gnt_sel = (last == SRC_A) ? SRC_B : SRC_A;
        end else if (req[1]) begin
            gnt_sel = SRC_B;
        end else begin
            gnt_sel = SRC_A;
        end
    end

endmodule

// File: rtl/pkt_rr_arb2.sv
// Merges two sop/eop-framed byte streams into one, granting whole packets
// round-robin and repairing framing faults (stray, overlong, restarted packets).
module pkt_rr_arb2
    import pkt_rr_arb2_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MAX_LEN = 256,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_vld,
    input  logic              a_sop,
    input  logic              a_eop,
    input  logic [DATA_W-1:0] a_din,
    output logic              a_rdy,
    input  logic              b_vld,
    input  logic              b_sop,
    input  logic              b_eop,
    input  logic [DATA_W-1:0] b_din,
    output logic              b_rdy,
    output logic              dout_vld,
    output logic              dout_sop,
    output logic              dout_eop,
    output logic [DATA_W-1:0] dout,
    output logic              err,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int                BCNT_W    = $clog2(MAX_LEN + 1);
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(MAX_LEN - 1);

    state_t              state_r;
    state_t              next_state_s;
    logic                last_grant_r;
    logic [BCNT_W-1:0]   beat_cnt_r;
    logic [1:0]          req_s;
    logic                pick_valid_s;
    logic                pick_sel_s;
    logic                own_a_s;
    logic                in_gnt_s;
    logic                src_vld_s;
    logic                src_sop_s;
    logic                src_eop_s;
    logic [DATA_W-1:0]   src_din_s;
    logic                fwd_s;
    logic                first_s;
    logic                restart_s;
    logic                overlong_s;
    logic                pkt_end_s;
    logic                err_s;

    assign req_s = {b_vld & b_sop, a_vld & a_sop};

    pkt_rr_arb2_rr_pick2 u_pick (
        .req       (req_s),
        .last      (last_grant_r),
        .gnt_valid (pick_valid_s),
        .gnt_sel   (pick_sel_s)
    );

    // Select the owning source and classify the beat being accepted from it.
    always_comb begin
        own_a_s  = owned_by_a(state_r);
        in_gnt_s = (state_r == ST_GNT_A) || (state_r == ST_GNT_B);
        if (own_a_s) begin
            src_vld_s = a_vld;
            src_sop_s = a_sop;
            src_eop_s = a_eop;
            src_din_s = a_din;
        end else begin
            src_vld_s = b_vld;
            src_sop_s = b_sop;
            src_eop_s = b_eop;
            src_din_s = b_din;
        end
        fwd_s      = in_gnt_s & src_vld_s;
        first_s    = (beat_cnt_r == {BCNT_W{1'b0}});
        // A restart wins over the length limit: the packet is already broken.
        restart_s  = fwd_s & src_sop_s & ~first_s;
        overlong_s = fwd_s & ~restart_s & ~src_eop_s & (beat_cnt_r == LAST_BEAT);
        pkt_end_s  = fwd_s & (restart_s | src_eop_s | overlong_s);
        err_s      = restart_s | overlong_s;
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    next_state_s = (pick_sel_s == SRC_A) ? ST_GNT_A : ST_GNT_B;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_GNT_A, ST_GNT_B: begin
                if (overlong_s) begin
                    next_state_s = own_a_s ? ST_DRP_A : ST_DRP_B;
                end else if (pkt_end_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_DRP_A, ST_DRP_B: begin
                if (src_vld_s & src_eop_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Ready outputs; in IDLE only non-sop (stray) beats are swallowed.
    always_comb begin
        case (state_r)
            ST_IDLE: begin
                a_rdy = a_vld & ~a_sop;
                b_rdy = b_vld & ~b_sop;
            end
            ST_GNT_A, ST_DRP_A: begin
                a_rdy = 1'b1;
                b_rdy = 1'b0;
            end
            ST_GNT_B, ST_DRP_B: begin
                a_rdy = 1'b0;
                b_rdy = 1'b1;
            end
            default: begin
                a_rdy = 1'b0;
                b_rdy = 1'b0;
            end
        endcase
    end

    // State register, grant history and beat position within the packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            last_grant_r <= SRC_B;
            beat_cnt_r   <= {BCNT_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            if ((state_r == ST_IDLE) && pick_valid_s) begin
                last_grant_r <= pick_sel_s;
            end
            if (pkt_end_s) begin
                beat_cnt_r <= {BCNT_W{1'b0}};
            end else if (fwd_s) begin
                beat_cnt_r <= beat_cnt_r + BCNT_W'(1);
            end
        end
    end

    // Merged output stage, one cycle behind acceptance, plus error counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_vld <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            dout     <= {DATA_W{1'b0}};
            err      <= 1'b0;
            err_cnt  <= {CNT_W{1'b0}};
        end else begin
            dout_vld <= fwd_s;
            dout_sop <= fwd_s & first_s;
            dout_eop <= pkt_end_s;
            if (fwd_s) begin
                dout <= src_din_s;
            end
            err <= err_s;
            if (err_s && (err_cnt != {CNT_W{1'b1}})) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule
